// File: rtl/dma_arb_pkg.sv
// Shared types and helpers for the two-channel AHB DMA bus arbiter.
// State encoding, channel indices, mux select values and pick helpers.
package dma_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } arb_state_t;

  localparam logic CH0     = 1'b0;
  localparam logic CH1     = 1'b1;
  localparam logic SEL_CH0 = 1'b1;
  localparam logic SEL_CH1 = 1'b0;

  function automatic arb_state_t gnt_state(
    input logic ch
  );
    return ch ? G1 : G0;
  endfunction

  function automatic logic [1:0] onehot(
    input logic ch
  );
    return ch ? 2'b10 : 2'b01;
  endfunction

  // Round-robin pick; only meaningful when req != 0.
  function automatic logic rr_pick(
    input logic [1:0] req,
    input logic       rr_last
  );
    if (&req) return ~rr_last;
    return req[1];
  endfunction

  // Fixed priority pick: ch0 whenever it asks.
  function automatic logic fixed_pick(
    input logic [1:0] req
  );
    return ~req[0];
  endfunction

endpackage

// File: rtl/dma_ch_arbiter_burst_cnt.sv
// Beat counter for the current grant: clear, increment with wrap, limit flag.
// Ports: clk, rst_n (sync), clr, inc -> at_limit (cnt == BURST_MAX-1).
module dma_burst_cnt #(
  parameter  int BURST_MAX = 16,
  localparam int CNT_W     = $clog2(BURST_MAX)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  logic [CNT_W-1:0] cnt;

  localparam logic [CNT_W-1:0] LIMIT =
    CNT_W'(BURST_MAX - 1);

  assign at_limit = (cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= at_limit ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dma_ch_arbiter.sv
// Two-channel round-robin arbiter with beat limit for the DMA master port.
// Ports: HCLK, HRESETn, req[1:0], beat_ack, hready -> gnt, sel, busy, switch_p.
// Macro DMA_ARB_FIXED_PRIO_EN selects fixed ch0 priority instead of round-robin.
module dma_ch_arbiter
  import dma_arb_pkg::*;
#(
  parameter int BURST_MAX = 16
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic [1:0] req,
  input  logic       beat_ack,
  input  logic       hready,
  output logic [1:0] gnt,
  output logic       sel,
  output logic       busy,
  output logic       switch_p
);

  arb_state_t state;
  arb_state_t state_nx;

  logic at_limit;
  logic clr;
  logic inc;
  logic sw_nx;

  logic own;
  logic own_req;
  logic oth_req;
  logic act;
  logic rel;
  logic pre;
  logic pre_ok;
  logic pick;

`ifdef DMA_ARB_FIXED_PRIO_EN
  // ch0 holds the bus for as long as it wants it.
  assign pre_ok = (own == CH1);
  assign pick   = fixed_pick(req);
`else
  logic rr_last;
  logic rr_nx;

  assign pre_ok = 1'b1;
  assign pick   = rr_pick(req, rr_last);
`endif

  assign own     = (state == G1);
  assign own_req = req[own];
  assign oth_req = req[~own];
  assign act     = (state != IDLE);

  // Release wins over preempt on the same cycle.
  assign rel = act & hready & ~own_req;
  assign pre = act & ~rel & hready & beat_ack
             & at_limit & oth_req & pre_ok;

  dma_burst_cnt #(
    .BURST_MAX (BURST_MAX)
  ) u_cnt (
    .clk      (HCLK),
    .rst_n    (HRESETn),
    .clr      (clr),
    .inc      (inc),
    .at_limit (at_limit)
  );

  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    inc      = 1'b0;
    sw_nx    = 1'b0;
`ifndef DMA_ARB_FIXED_PRIO_EN
    rr_nx    = rr_last;
`endif
    unique case (1'b1)
      !act: begin
        if (|req) begin
          state_nx = gnt_state(pick);
          clr      = 1'b1;
        end
      end
      rel: begin
        clr = 1'b1;
`ifndef DMA_ARB_FIXED_PRIO_EN
        rr_nx = own;
`endif
        if (oth_req) begin
          state_nx = gnt_state(~own);
          sw_nx    = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      pre: begin
        clr      = 1'b1;
        state_nx = gnt_state(~own);
        sw_nx    = 1'b1;
`ifndef DMA_ARB_FIXED_PRIO_EN
        rr_nx = own;
`endif
      end
      default: begin
        inc = beat_ack;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state    <= IDLE;
      gnt      <= 2'b00;
      sel      <= SEL_CH1;
      busy     <= 1'b0;
      switch_p <= 1'b0;
`ifndef DMA_ARB_FIXED_PRIO_EN
      rr_last  <= CH1;
`endif
    end else begin
      state    <= state_nx;
      busy     <= (state_nx != IDLE);
      switch_p <= sw_nx;
      if (state_nx == IDLE) begin
        gnt <= 2'b00;
      end else begin
        gnt <= onehot(state_nx == G1);
        sel <= (state_nx == G0) ? SEL_CH0 : SEL_CH1;
      end
`ifndef DMA_ARB_FIXED_PRIO_EN
      rr_last  <= rr_nx;
`endif
    end
  end

endmodule

// File: tb/tb_dma_ch_arbiter.sv
// Self-checking bench for dma_ch_arbiter (BURST_MAX=4).
// Vector table, hand sequences and random run against a reference model.
module tb_dma_ch_arbiter;

  localparam int BM = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic       ba;
  logic       hr;
  logic [1:0] gnt;
  logic       sel;
  logic       busy;
  logic       sw;

  int total = 0;
  int bad   = 0;

  dma_ch_arbiter #(
    .BURST_MAX (BM)
  ) dut (
    .HCLK     (clk),
    .HRESETn  (rst_n),
    .req      (req),
    .beat_ack (ba),
    .hready   (hr),
    .gnt      (gnt),
    .sel      (sel),
    .busy     (busy),
    .switch_p (sw)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rst;
    bit [1:0] req;
    bit       ba;
    bit       hr;
    bit [1:0] g;
    bit       s;
    bit       w;
  } vec_t;

  vec_t tv[20];

  // reference model: owner -1 = none
  int m_own;
  int m_beats;
  int m_last;
  bit m_sel;
  bit m_sw;

`ifdef DMA_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit [1:0] q,
                       input bit b, input bit h);
    rst_n = r;
    req   = q;
    ba    = b;
    hr    = h;
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input bit r, input bit [1:0] q,
                            input bit b, input bit h);
    int o;
    int oth;
    m_sw = 1'b0;
    if (!r) begin
      m_own = -1; m_beats = 0; m_last = 1; m_sel = 1'b0;
      return;
    end
    if (m_own < 0) begin
      if (q != 2'b00) begin
        if (q == 2'b11) m_own = FIXED ? 0 : 1 - m_last;
        else            m_own = q[0] ? 0 : 1;
        m_beats = 0;
      end
    end else begin
      o   = m_own;
      oth = 1 - o;
      if (h && !q[o]) begin
        m_last = o; m_beats = 0;
        if (q[oth]) begin m_own = oth; m_sw = 1'b1; end
        else m_own = -1;
      end else if (h && b && m_beats == BM - 1 && q[oth]
                   && (!FIXED || o == 1)) begin
        m_last = o; m_own = oth; m_beats = 0; m_sw = 1'b1;
      end else if (b) begin
        m_beats = (m_beats + 1) % BM;
      end
    end
    if (m_own == 0) m_sel = 1'b1;
    else if (m_own == 1) m_sel = 1'b0;
  endtask

  initial begin
    bit [1:0] rq;
    bit       rb;
    bit       rh;
    bit       rr;
    logic [1:0] eg;
    bit       ew;

    //          rst req  ba hr  gnt  sel sw
    tv[0]  = '{0, 2'b11, 0, 1, 2'b00, 0, 0};
    tv[1]  = '{0, 2'b11, 0, 1, 2'b00, 0, 0};
    tv[2]  = '{1, 2'b11, 0, 1, 2'b01, 1, 0};
    tv[3]  = '{1, 2'b00, 0, 1, 2'b00, 1, 0};
    tv[4]  = '{1, 2'b10, 0, 1, 2'b10, 0, 0};
    tv[5]  = '{1, 2'b10, 1, 1, 2'b10, 0, 0};
    tv[6]  = '{1, 2'b10, 1, 1, 2'b10, 0, 0};
    tv[7]  = '{1, 2'b10, 1, 1, 2'b10, 0, 0};
    tv[8]  = '{1, 2'b10, 1, 1, 2'b10, 0, 0};
    tv[9]  = '{1, 2'b10, 1, 1, 2'b10, 0, 0};
    tv[10] = '{1, 2'b00, 0, 1, 2'b00, 0, 0};
    tv[11] = '{1, 2'b01, 0, 1, 2'b01, 1, 0};
    tv[12] = '{1, 2'b11, 0, 1, 2'b01, 1, 0};
    tv[13] = '{1, 2'b10, 0, 0, 2'b01, 1, 0};
    tv[14] = '{1, 2'b10, 0, 0, 2'b01, 1, 0};
    tv[15] = '{1, 2'b10, 0, 0, 2'b01, 1, 0};
    tv[16] = '{1, 2'b10, 0, 1, 2'b10, 0, 1};
    tv[17] = '{1, 2'b10, 0, 1, 2'b10, 0, 0};
    tv[18] = '{0, 2'b10, 1, 1, 2'b00, 0, 0};
    tv[19] = '{1, 2'b00, 1, 1, 2'b00, 0, 0};

    for (int i = 0; i < 20; i++) begin
      drive(tv[i].rst, tv[i].req, tv[i].ba, tv[i].hr);
      chk($sformatf("vec%0d_gnt", i), 8'(gnt), 8'(tv[i].g));
      chk($sformatf("vec%0d_sel", i), 8'(sel), 8'(tv[i].s));
      chk($sformatf("vec%0d_sw", i), 8'(sw), 8'(tv[i].w));
      chk($sformatf("vec%0d_busy", i), 8'(busy),
          8'(|tv[i].g));
    end

    // both requesting, continuous beats: 4-beat slices
    drive(0, 2'b11, 0, 1);
    for (int k = 1; k <= 16; k++) begin
      drive(1, 2'b11, 1, 1);
      if (FIXED) begin
        eg = 2'b01; ew = 1'b0;
      end else begin
        eg = (((k - 1) / 4) % 2 == 0) ? 2'b01 : 2'b10;
        ew = (k > 1) && ((k - 1) % 4 == 0);
      end
      chk($sformatf("alt%0d_gnt", k), 8'(gnt), 8'(eg));
      chk($sformatf("alt%0d_sw", k), 8'(sw), 8'(ew));
    end
    if (FIXED) begin
      drive(1, 2'b10, 1, 1);
      chk("fix_hand_gnt", 8'(gnt), 8'(2'b10));
      chk("fix_hand_sw", 8'(sw), 8'(1));
    end

    // sole requester never switches
    drive(0, 2'b00, 0, 1);
    for (int k = 0; k < 40; k++) begin
      drive(1, 2'b01, 1, 1);
      chk("solo_gnt", 8'(gnt), 8'(2'b01));
      chk("solo_sw", 8'(sw), 8'(0));
    end

    // randomized run against the model
    model_step(0, 2'b00, 0, 1);
    drive(0, 2'b00, 0, 1);
    rq = 2'b00;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0) rq[0] = ~rq[0];
      if ($urandom_range(0, 9) == 0) rq[1] = ~rq[1];
      rb = ($urandom_range(0, 2) != 0);
      rh = ($urandom_range(0, 4) != 0);
      rr = ($urandom_range(0, 299) != 0);
      model_step(rr, rq, rb, rh);
      drive(rr, rq, rb, rh);
      eg = (m_own < 0) ? 2'b00 : (m_own == 0 ? 2'b01 : 2'b10);
      chk("rnd_gnt", 8'(gnt), 8'(eg));
      chk("rnd_sel", 8'(sel), 8'(m_sel));
      chk("rnd_busy", 8'(busy), 8'(m_own >= 0));
      chk("rnd_sw", 8'(sw), 8'(m_sw));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_ch_arbiter.md
Name: dma_ch_arbiter

Overview:
- Two-channel arbiter for the AHB DMA shared master port.
- Decides which channel owns the bus and drives the select line of the DMA 2:1 channel mux.
- Round-robin by default, with a per-grant beat limit so neither channel starves the other.
- Sits between the two channel engines and the master-port mux/AHB interface.

Parameters:
- BURST_MAX, 16: maximum beats a channel keeps the grant while the other channel is requesting (legal 2..256).
- CNT_W, $clog2(BURST_MAX): beat counter width; derived, not overridden.

Ports:
- HCLK  input  1  system clock.
- HRESETn  input  1  reset; one clock; reset is synchronous and active-low.
- req  input  2  channel bus requests; bit0 = ch0, bit1 = ch1; level, held until the channel's transfer is done.
- beat_ack  input  1  pulse: one data beat completed on the master port for the granted channel.
- hready  input  1  AHB HREADY; re-arbitration only happens at hready=1.
- gnt  output  2  one-hot grant; never 2'b11.
- sel  output  1  mux selector: 1 routes ch0 (data_in), 0 routes ch1 (data_in_2).
- busy  output  1  |gnt.
- switch_p  output  1  one-cycle pulse on any grant change between channels.

Behaviour:
- Reset (HRESETn=0 at a HCLK edge): state=IDLE, gnt=0, sel=0, busy=0, switch_p=0, cnt=0, rr_last=1 (ch0 wins first).
- All outputs are registered.
- States:
  - IDLE: no grant.
  - G0: ch0 granted, sel=1.
  - G1: ch1 granted, sel=0.
- IDLE transitions:
  - req sampled at edge N gives gnt at N+1 (1-cycle latency).
  - Both requesting: the channel other than rr_last wins.
  - hready is not required to leave IDLE.
- G0/G1 stay conditions: the owner keeps the grant while its req=1 and cnt has not hit the limit.
- Release: the owner drops req at a cycle with hready=1.
  - Other req=1: go directly to the other grant next cycle, no IDLE bubble, switch_p=1.
  - Otherwise go to IDLE.
- Preempt: beat_ack with cnt==BURST_MAX-1, hready=1, and the other req=1.
  - Switch to the other channel, cnt cleared, switch_p=1.
  - If the other req=0, cnt wraps to 0 and the grant is retained.
- Owner req drop while hready=0: grant held until the first hready=1 cycle.
- cnt:
  - Cleared on every new grant.
  - Increments on beat_ack only when gnt!=0.
  - beat_ack in IDLE is ignored.
- rr_last: updated to the channel index whenever that channel's grant ends.
- sel: holds its last value in IDLE, so the mux output stays stable.
- Simultaneous release and preempt on the same cycle: treated as release, same outcome.
- Reset mid-burst: grant removed the next edge, no switch_p.

Optional Feature:
- Macro DMA_ARB_FIXED_PRIO_EN.
- Defined:
  - ch0 wins every arbitration point (IDLE entry, release, preempt); rr_last unused.
  - The BURST_MAX limit still preempts ch1 in favour of ch0.
  - ch0 is never preempted; ch1 starvation is accepted.
- Undefined: round-robin behaviour as above.

Decomposition:
- Package dma_arb_pkg:
  - typedef enum logic [1:0] arb_state_t {IDLE, G0, G1}.
  - localparams CH0=0, CH1=1.
  - SEL_CH0=1'b1, SEL_CH1=1'b0.
- One natural sub-module, dma_burst_cnt: clear/increment/limit-flag counter parameterised by BURST_MAX.
- The FSM stays in dma_ch_arbiter.

Test Plan:
- Reset with req=2'b11 held: gnt=0, sel=0 while HRESETn=0. First cycle after release: gnt=2'b01, sel=1.
- Only ch1 requests, 5 beats, then req=0 with hready=1: gnt=2'b10 one cycle after req. gnt=0 one cycle after drop; sel stays 0.
- Both request, BURST_MAX=4, continuous beat_ack, hready=1: grants alternate 4 beats ch0 / 4 beats ch1, with switch_p pulses at beats 4 and 8.
- ch0 sole requester for 40 beats, BURST_MAX=16: gnt stays 2'b01, cnt wraps at 16 and 32, switch_p never asserted.
- ch0 drops req while hready=0 for 3 cycles: gnt held 3 cycles, moves to ch1 the cycle after hready=1.
- DMA_ARB_FIXED_PRIO_EN defined, both request, BURST_MAX=4: ch0 never loses gnt; ch1 granted only after ch0 req=0.
